// File: rtl/mmio_controller.sv
// mmio_controller: address decode, button press capture and VGA output queue between CPU data port and RAM.
// Define MMIO_BTN_LATCH_EN for edge-latched, clear-on-read buttons; otherwise button reads return the synchronised level.
module mmio_controller #(
  parameter logic [31:0] ADDR_OUT    = 32'd2000,
  parameter logic [31:0] ADDR_BTNL   = 32'd3000,
  parameter logic [31:0] ADDR_BTNR   = 32'd4000,
  parameter logic [31:0] ADDR_BTNU   = 32'd5000,
  parameter logic [31:0] ADDR_BTND   = 32'd6000,
  parameter logic [31:0] ADDR_STATUS = 32'd7000,
  parameter int          OUT_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  input  logic [3:0]  btn_in,
  output logic [31:0] vga_data,
  output logic        vga_valid,
  input  logic        vga_ready
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;

  logic [3:0]    s1_q, s2_q, btn_val, btn_hit;
  logic          hit_out, hit_st, hit, rd, push, pop, full, push_ok, drop;
  logic          sel_io_q, ovf_q, ovf_d;
  logic [31:0]   mmio_q, mmio_d;
  logic [31:0]   mem_q [OUT_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] count_q, count_d;

  assign btn_hit  = {address_dmem == ADDR_BTND, address_dmem == ADDR_BTNU,
                     address_dmem == ADDR_BTNR, address_dmem == ADDR_BTNL};
  assign hit_out  = address_dmem == ADDR_OUT;
  assign hit_st   = address_dmem == ADDR_STATUS;
  assign hit      = |btn_hit | hit_out | hit_st;
  assign rd       = ~wren;
  assign ram_wren = wren & ~hit;

  assign vga_valid = count_q != '0;
  assign vga_data  = vga_valid ? mem_q[rp_q] : '0;
  assign pop       = vga_valid & vga_ready;
  assign push      = wren & hit_out;
  assign full      = count_q == CW'(OUT_DEPTH);
  // A pop frees the head slot in the same cycle, so a full queue can still accept.
  assign push_ok   = push & (~full | pop);
  assign drop      = push & ~push_ok;
  assign count_d   = count_q + CW'(push_ok) - CW'(pop);
  assign ovf_d     = drop | (ovf_q & ~(rd & hit_st));

`ifdef MMIO_BTN_LATCH_EN
  logic [3:0] s2p_q, pend_q, pend_d, btn_edge;
  assign btn_edge = s2_q & ~s2p_q;
  assign btn_val  = pend_q | btn_edge;
  // An edge seen during the read is reported by it and must not re-arm pending.
  assign pend_d   = btn_val & ~(rd ? btn_hit : 4'b0);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2p_q  <= '0;
      pend_q <= '0;
    end else begin
      s2p_q  <= s2_q;
      pend_q <= pend_d;
    end
  end
`else
  assign btn_val = s2_q;
`endif

  assign mmio_d = |btn_hit ? {31'b0, |(btn_hit & btn_val)}
                : hit_st   ? {15'b0, ovf_q, 8'b0, 8'(count_q)} : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      sel_io_q <= 1'b0;
      mmio_q   <= '0;
      ovf_q    <= 1'b0;
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      s1_q     <= btn_in;
      s2_q     <= s1_q;
      sel_io_q <= hit;
      mmio_q   <= mmio_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      wp_q     <= wp_q + PW'(push_ok);
      rp_q     <= rp_q + PW'(pop);
      if (push_ok) mem_q[wp_q] <= data;
    end
  end

  assign q_dmem = sel_io_q ? mmio_q : ram_q;
endmodule

// File: tb/tb_mmio_controller.sv
// tb_mmio_controller: directed vectors for decode, button capture, status and VGA queue of mmio_controller.
`timescale 1ns/1ps
module tb_mmio_controller;
  logic        clock = 1'b0, reset = 1'b0, wren = 1'b0, ram_wren, vga_valid, vga_ready = 1'b0;
  logic [31:0] address_dmem = '0, data = '0, q_dmem, ram_q = '0, vga_data;
  logic [3:0]  btn_in = '0;
  logic [31:0] ram [256];
  int          n_vec = 0, n_bad = 0;

  mmio_controller dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data), .wren(wren),
    .q_dmem(q_dmem), .ram_wren(ram_wren), .ram_q(ram_q), .btn_in(btn_in),
    .vga_data(vga_data), .vga_valid(vga_valid), .vga_ready(vga_ready)
  );

  always #5 clock = ~clock;

  initial for (int i = 0; i < 256; i++) ram[i] = '0;
  always @(posedge clock) begin
    if (ram_wren) ram[address_dmem[7:0]] <= data;
    ram_q <= ram_wren ? data : ram[address_dmem[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic exp_we, input string tag);
    address_dmem = a; data = d; wren = 1'b1;
    #1 check(tag, {31'b0, ram_wren}, {31'b0, exp_we});
    @(posedge clock); #1;
    wren = 1'b0; address_dmem = '0;
  endtask

  task automatic push(input logic [31:0] d);
    address_dmem = 32'd2000; data = d; wren = 1'b1;
    @(posedge clock); #1;
    wren = 1'b0; address_dmem = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    address_dmem = a; wren = 1'b0;
    @(posedge clock); #1;
    address_dmem = '0;
    check(tag, q_dmem, exp);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", {31'b0, vga_valid}, 32'd0);
    check("rst_data", vga_data, 32'd0);
    check("rst_q", q_dmem, 32'd0);
    check("rst_ramwe", {31'b0, ram_wren}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 10; i <= 14; i++) wr(32'd2000, i, 1'b0, "out_no_ramwe");
    rd(32'd7000, 32'h0001_0004, "status_ovf");
    rd(32'd7000, 32'h0000_0004, "status_clr");
    check("head10", vga_data, 32'd10);
    repeat (2) @(posedge clock);
    #1 check("head_hold", vga_data, 32'd10);
    check("valid_full", {31'b0, vga_valid}, 32'd1);
    vga_ready = 1'b1;
    push(32'd99);
    vga_ready = 1'b0;
    rd(32'd7000, 32'h0000_0004, "status_push_pop");
    vga_ready = 1'b1;
    check("drain0", vga_data, 32'd11);
    @(posedge clock); #1 check("drain1", vga_data, 32'd12);
    @(posedge clock); #1 check("drain2", vga_data, 32'd13);
    @(posedge clock); #1 check("drain3", vga_data, 32'd99);
    @(posedge clock); #1;
    check("empty_valid", {31'b0, vga_valid}, 32'd0);
    check("empty_data", vga_data, 32'd0);
    vga_ready = 1'b0;

    push(32'd1); push(32'd2); push(32'd3);
    check("pre_rst_valid", {31'b0, vga_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, vga_valid}, 32'd0);
    check("mid_rst_data", vga_data, 32'd0);
    @(posedge clock); #1 reset = 1'b1;
    rd(32'd7000, 32'd0, "status_after_rst");

    wr(32'd3000, 32'hABCD, 1'b0, "btn_wr_ramwe");
    wr(32'd6000, 32'hABCD, 1'b0, "btnd_wr_ramwe");
    check("ram_untouched_l", ram[8'hB8], 32'd0);
    check("ram_untouched_d", ram[8'h70], 32'd0);
    wr(32'd100, 32'h55, 1'b1, "ram_wr_ramwe");
    rd(32'd100, 32'h55, "ram_rd");

    btn_in[0] = 1'b1;
`ifndef MMIO_BTN_LATCH_EN
    repeat (5) @(posedge clock);
    #1 rd(32'd3000, 32'd1, "btnl_level_held");
`endif
    repeat (100) @(posedge clock);
    #1 btn_in[0] = 1'b0;
    repeat (4) @(posedge clock);
    #1;
`ifdef MMIO_BTN_LATCH_EN
    rd(32'd3000, 32'd1, "btnl_latched");
`else
    rd(32'd3000, 32'd0, "btnl_released");
`endif
    rd(32'd3000, 32'd0, "btnl_second");

    btn_in[2] = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    rd(32'd5000, 32'd1, "btnu_coincide");
`ifdef MMIO_BTN_LATCH_EN
    rd(32'd5000, 32'd0, "btnu_no_rereport");
`else
    rd(32'd5000, 32'd1, "btnu_level");
`endif
    btn_in[2] = 1'b0;
    repeat (4) @(posedge clock);
    #1 rd(32'd5000, 32'd0, "btnu_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mmio_controller.md
# mmio_controller

Memory-mapped I/O bridge between the processor data-memory port and the RAM, the debounced push buttons and the VGA controller. It decodes fixed I/O addresses and synchronises the buttons, latching press events until the processor reads them. Writes to the output address are queued in a small FIFO that drains to the VGA controller through a valid/ready handshake. All other accesses go to RAM, with the same one-cycle read latency.

## Interface
- ADDR_OUT, 2000: write-only VGA output queue address
- ADDR_BTNL / ADDR_BTNR / ADDR_BTNU / ADDR_BTND, 3000 / 4000 / 5000 / 6000: read-only button addresses
- ADDR_STATUS, 7000: read-only queue status address
- OUT_DEPTH, 4: output FIFO depth, power of two, 2..16

Ports:
- clock  in  1  system clock, all state updates on its rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- address_dmem  in  32  processor data address, full 32-bit equality decode
- data  in  32  processor write data
- wren  in  1  processor write enable
- q_dmem  out  32  read data to processor
- ram_wren  out  1  gated RAM write enable
- ram_q  in  32  RAM read data (synchronous RAM, valid one cycle after address)
- btn_in  in  4  debounced buttons {D,U,R,L}, asynchronous to clock
- vga_data  out  32  FIFO head word
- vga_valid  out  1  FIFO non-empty
- vga_ready  in  1  VGA accepts head this cycle

## Operation
- I/O hit = address_dmem equals any ADDR_* parameter. ram_wren = wren & ~hit. Writes to button/status addresses are ignored.
- Button path, per bit:
  - two-flop synchroniser s1→s2, then s2_prev.
  - edge = s2 & ~s2_prev.
  - pending bit is set by edge.
- Button read, with wren=0 at ADDR_BTNx: the returned value is {31'b0, pending|edge}.
  - pending clears on that same edge.
  - A press edge coinciding with a read is reported by that read and not re-reported.
- Status read returns {15'b0, overflow, 8'b0, count}.
  - count is zero-extended occupancy (0..OUT_DEPTH), sampled before any same-cycle push/pop.
  - The read clears overflow, unless an overflow occurs the same cycle, in which case overflow stays 1.
- Push: wren=1 at ADDR_OUT pushes data.
  - Accepted if count<OUT_DEPTH, or if a pop occurs the same cycle (full with simultaneous pop: count unchanged, order preserved).
  - Otherwise the word is dropped and the sticky overflow bit is set.
- Pop: vga_valid & vga_ready.
  - vga_data is the head entry; it holds its value while vga_valid=1 and vga_ready=0.
  - vga_data=0 when empty.
- Pointers wrap modulo OUT_DEPTH; count is a separate counter of width clog2(OUT_DEPTH)+1.

## Timing
- Reset values:
  - q_dmem=0, vga_valid=0, vga_data=0
  - pending, s1, s2, s2_prev, overflow, pointers and count all 0
  - ram_wren follows wren & ~hit combinationally (0 when wren=0).
- Reads have one-cycle latency.
  - At the edge sampling the address, sel_io and mmio_q are registered.
  - After that edge, q_dmem = sel_io ? mmio_q : ram_q (combinational mux on registered select).
- btn_in rising before edge k sets pending at edge k+2; a read sampled at edge k+2 already returns 1.
- A push at edge n makes vga_valid=1 after edge n when the FIFO was empty; there is no bypass of the head register.
- Reset asserted mid-transfer discards queued words and pending presses. The first operation after release behaves as from power-up.

## Configuration
- MMIO_BTN_LATCH_EN defined: edge-latched, clear-on-read button behaviour as above.
- Not defined: button reads return the synchronised level s2; pending logic is removed; reads have no side effect.
- FIFO and status behave identically in both builds.

## Test plan
- Reset low mid-stream with 3 queued words → vga_valid=0, vga_data=0, status read after release returns 0.
- btn_in[0] pulses high for 1 µs and then releases, followed by a read of 3000 → q_dmem=1. A second read of 3000 → 0. Without MMIO_BTN_LATCH_EN, the read after release → 0.
- Push 5 words (10..14) with vga_ready=0 and OUT_DEPTH=4 → status=0x0001_0004. A second status read → 0x0000_0004. Draining yields 10, 11, 12, 13.
- FIFO full, push 99 with vga_ready=1 in the same cycle → head 10 popped, count stays 4, 99 appears last, overflow=0.
- Write 0xABCD to 3000 and 6000 → ram_wren=0, RAM unchanged. Write 0x55 to 100 → ram_wren=1. The read of 100 one cycle later returns 0x55.
- Button edge coinciding with a read of 5000 → that read returns 1, and the next read returns 0.
